// File: rtl/coproc_pkg.sv
// Shared constants and FSM state type for the coprocessor byte sequencer.
package coproc_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_READ = 8'h02;
    localparam logic [7:0] CMD_CRST = 8'h03;

    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_ERR = 8'hEE;

    localparam logic [2:0] SEL_DIN     = 3'd0;
    localparam logic [2:0] SEL_DIN_DLY = 3'd1;
    localparam logic [2:0] SEL_POS     = 3'd2;
    localparam logic [2:0] SEL_FINAL   = 3'd3;
    localparam logic [2:0] SEL_COUNT   = 3'd4;

    typedef enum logic [3:0] {
        StIdle,
        StLoadPay,
        StIssue,
        StSettle,
        StAckSend,
        StReadSel,
        StReadCap,
        StReadSend,
        StRstPulse,
        StErrSend
    } seq_state_e;

endpackage

// File: rtl/seq_tx_serializer.sv
// LSB-first byte serializer: loads a full word or a single byte and streams it
// over a valid/ready handshake, pulsing done as the last byte is accepted.
module seq_tx_serializer
    import coproc_pkg::*;
#(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_word,
    input  logic             load_byte,
    input  logic [WIDTH-1:0] word,
    input  logic [7:0]       byte_in,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             done
);

    localparam int unsigned NumBytes = WIDTH / 8;
    localparam int unsigned CntW     = $clog2(NumBytes + 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]  left_q, left_d;
    logic             accept;

    assign tx_valid = (left_q != '0);
    assign tx_data  = shift_q[7:0];
    assign accept   = tx_valid && tx_ready;
    assign done     = accept && (left_q == CntW'(1));

    always_comb begin
        shift_d = shift_q;
        left_d  = left_q;
        if (load_word) begin
            shift_d = word;
            left_d  = CntW'(NumBytes);
        end else if (load_byte) begin
            shift_d = WIDTH'(byte_in);
            left_d  = CntW'(1);
        end else if (accept) begin
            shift_d = shift_q >> 8;
            left_d  = left_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            left_q  <= '0;
        end else begin
            shift_q <= shift_d;
            left_q  <= left_d;
        end
    end

endmodule

// File: rtl/coproc_sequencer.sv
// UART byte-stream command sequencer for the compute coprocessor.
// Define SEQ_TIMEOUT_EN to build the inter-byte idle timeout.
module coproc_sequencer
    import coproc_pkg::*;
#(
    parameter int unsigned WIDTH_DIN      = 128,
    parameter int unsigned WIDTH_DOUT     = 128,
    parameter int unsigned SETTLE_CYCLES  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [WIDTH_DIN-1:0]  copro_din,
    output logic                  copro_din_valid,
    output logic                  copro_rst,
    output logic [2:0]            copro_sel,
    input  logic [WIDTH_DOUT-1:0] copro_dout,
    output logic                  busy,
    output logic                  overrun
);

    localparam int unsigned NumPay = WIDTH_DIN / 8;
    localparam int unsigned PayW   = $clog2(NumPay + 1);
    localparam int unsigned SetW   = $clog2(SETTLE_CYCLES + 1);

    seq_state_e           state_q, state_d;
    logic [WIDTH_DIN-1:0] din_q, din_d;
    logic [2:0]           sel_q, sel_d;
    logic [PayW-1:0]      pay_q, pay_d;
    logic [SetW-1:0]      settle_q, settle_d;
    logic                 overrun_q, overrun_d;
    logic                 ser_load_word, ser_load_byte, ser_done;
    logic [7:0]           ser_byte;
    logic                 timeout;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

    logic [IdleW-1:0] idle_q;
    logic             idle_run;

    assign idle_run = (state_q == StLoadPay) || (state_q == StReadSel);
    assign timeout  = idle_run && !rx_valid && (idle_q == IdleW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !idle_run || rx_valid || timeout) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + IdleW'(1);
        end
    end
`else
    // TIMEOUT_CYCLES only matters when the idle counter is built.
    assign timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d         = state_q;
        din_d           = din_q;
        sel_d           = sel_q;
        pay_d           = pay_q;
        settle_d        = settle_q;
        overrun_d       = overrun_q;
        ser_load_word   = 1'b0;
        ser_load_byte   = 1'b0;
        ser_byte        = RSP_ACK;
        copro_din_valid = 1'b0;
        copro_rst       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_LOAD: begin
                            state_d = StLoadPay;
                            pay_d   = '0;
                        end
                        CMD_READ: state_d = StReadSel;
                        CMD_CRST: state_d = StRstPulse;
                        default: begin
                            state_d       = StErrSend;
                            ser_load_byte = 1'b1;
                            ser_byte      = RSP_ERR;
                        end
                    endcase
                end
            end
            StLoadPay: begin
                if (timeout) begin
                    state_d       = StErrSend;
                    pay_d         = '0;
                    ser_load_byte = 1'b1;
                    ser_byte      = RSP_ERR;
                end else if (rx_valid) begin
                    // Shift right so byte k lands at [8k+7:8k] once the frame is full.
                    din_d = {rx_data, din_q[WIDTH_DIN-1:8]};
                    if (pay_q == PayW'(NumPay - 1)) begin
                        pay_d   = '0;
                        state_d = StIssue;
                    end else begin
                        pay_d = pay_q + PayW'(1);
                    end
                end
            end
            StIssue: begin
                copro_din_valid = 1'b1;
                settle_d        = '0;
                state_d         = StSettle;
            end
            StSettle: begin
                if (settle_q == SetW'(SETTLE_CYCLES - 1)) begin
                    state_d       = StAckSend;
                    ser_load_byte = 1'b1;
                end else begin
                    settle_d = settle_q + SetW'(1);
                end
            end
            StAckSend, StErrSend, StReadSend: begin
                if (ser_done) state_d = StIdle;
            end
            StReadSel: begin
                if (timeout) begin
                    state_d       = StErrSend;
                    ser_load_byte = 1'b1;
                    ser_byte      = RSP_ERR;
                end else if (rx_valid) begin
                    sel_d   = rx_data[2:0];
                    state_d = StReadCap;
                end
            end
            StReadCap: begin
                ser_load_word = 1'b1;
                state_d       = StReadSend;
            end
            StRstPulse: begin
                copro_rst     = 1'b1;
                ser_load_byte = 1'b1;
                state_d       = StAckSend;
            end
            default: state_d = StIdle;
        endcase

        if (rx_valid && !(state_q inside {StIdle, StLoadPay, StReadSel})) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            din_q     <= '0;
            sel_q     <= '0;
            pay_q     <= '0;
            settle_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            din_q     <= din_d;
            sel_q     <= sel_d;
            pay_q     <= pay_d;
            settle_q  <= settle_d;
            overrun_q <= overrun_d;
        end
    end

    seq_tx_serializer #(
        .WIDTH (WIDTH_DOUT)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .load_word (ser_load_word),
        .load_byte (ser_load_byte),
        .word      (copro_dout),
        .byte_in   (ser_byte),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (ser_done)
    );

    assign copro_din = din_q;
    assign copro_sel = sel_q;
    assign busy      = (state_q != StIdle);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_coproc_sequencer.sv
// Directed bench for coproc_sequencer with a scoreboard of expected TX bytes,
// strobe/reset-pulse cycles and the sticky overrun flag.
module tb_coproc_sequencer;

    localparam int unsigned WD     = 128;
    localparam int unsigned SETTLE = 16;
    localparam int unsigned TMO    = 50;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [WD-1:0]   copro_din;
    logic            copro_din_valid;
    logic            copro_rst;
    logic [2:0]      copro_sel;
    logic [WD-1:0]   copro_dout;
    logic            busy;
    logic            overrun;

    always #5 clk = ~clk;

    coproc_sequencer #(
        .WIDTH_DIN      (WD),
        .WIDTH_DOUT     (WD),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .copro_din       (copro_din),
        .copro_din_valid (copro_din_valid),
        .copro_rst       (copro_rst),
        .copro_sel       (copro_sel),
        .copro_dout      (copro_dout),
        .busy            (busy),
        .overrun         (overrun)
    );

    // Coprocessor stub: select 4 returns 0x1234, others a byte pattern tagged by select.
    always_comb begin
        if (copro_sel == 3'd4) copro_dout = 128'h1234;
        else                   copro_dout = {16{5'b10100, copro_sel}};
    end

    typedef struct {
        logic [7:0] b;
        int         min_cyc;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            exp_strobe_cyc = -1;
    int            exp_rst_cyc = -1;
    logic [WD-1:0] exp_din = '0;
    logic          ovr_exp = 1'b0;
    logic          chk_en = 1'b0;
    logic          slow = 1'b0;
    logic          hold_prev = 1'b0;
    logic [7:0]    prev_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // tx_ready accepts only one cycle in three while slow is set.
    initial begin
        int ph = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = slow ? (ph == 0) : 1'b1;
            ph = (ph + 1) % 3;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("din_valid", WD'(copro_din_valid), WD'(cyc == exp_strobe_cyc));
            if (copro_din_valid && cyc == exp_strobe_cyc) check("din_value", copro_din, exp_din);
            check("copro_rst", WD'(copro_rst), WD'(cyc == exp_rst_cyc));
            check("overrun", WD'(overrun), WD'(ovr_exp));
            if (hold_prev) begin
                check("tx_hold_valid", WD'(tx_valid), WD'(1'b1));
                check("tx_hold_data", WD'(tx_data), WD'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_spurious: got byte 0x%0h, expected no transmission", tx_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("tx_byte", WD'(tx_data), WD'(e.b));
                    if (e.min_cyc > 0) check("ack_gap", WD'(cyc >= e.min_cyc), WD'(1'b1));
                end
            end
            hold_prev = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
    end

    task automatic push(input logic [7:0] b, input int min_cyc);
        exp_t e;
        e.b       = b;
        e.min_cyc = min_cyc;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_load(input logic [WD-1:0] v);
        send_byte(8'h01);
        for (int i = 0; i < int'(WD / 8); i++) send_byte(v[8*i +: 8]);
        exp_din        = v;
        exp_strobe_cyc = cyc;
        push(8'h06, cyc + int'(SETTLE) + 1);
    endtask

    task automatic send_read(input logic [2:0] sel, input logic [WD-1:0] v);
        for (int i = 0; i < int'(WD / 8); i++) push(v[8*i +: 8], 0);
        send_byte(8'h02);
        send_byte({5'b11111, sel});
    endtask

    task automatic send_crst();
        push(8'h06, 0);
        send_byte(8'h03);
        exp_rst_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s_wait: busy=%0b with %0d bytes pending, expected idle", name, busy,
                     exp_q.size());
            exp_q.delete();
        end
        idle(2);
        check({name, "_busy"}, WD'(busy), WD'(1'b0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        ovr_exp   = 1'b0;
        hold_prev = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(3);
        rst = 1'b0;
        check("rst_tx_valid", WD'(tx_valid), '0);
        check("rst_tx_data", WD'(tx_data), '0);
        check("rst_din", copro_din, '0);
        check("rst_din_valid", WD'(copro_din_valid), '0);
        check("rst_copro_rst", WD'(copro_rst), '0);
        check("rst_sel", WD'(copro_sel), '0);
        check("rst_busy", WD'(busy), '0);
        check("rst_overrun", WD'(overrun), '0);
        chk_en = 1'b1;

        // LOAD of value 5, strobe and delayed ack
        send_load(128'h5);
        wait_done("load5");
        check("load5_din", copro_din, 128'h5);

        // READ select 4 at full rate, then with a stalling UART
        send_read(3'd4, 128'h1234);
        wait_done("read4");
        check("read4_sel", WD'(copro_sel), WD'(3'd4));
        slow = 1'b1;
        send_read(3'd4, 128'h1234);
        wait_done("read4_slow");
        send_crst();
        wait_done("crst_slow");
        slow = 1'b0;
        send_read(3'd3, {16{8'hA3}});
        wait_done("read3");
        check("read3_sel", WD'(copro_sel), WD'(3'd3));

        // Unknown command, then a normal LOAD and a coprocessor reset
        push(8'hEE, 0);
        send_byte(8'h7F);
        wait_done("err7f");
        send_load(128'h1f1e1d1c1b1a19181716151413121110);
        wait_done("load_seq");
        check("load_seq_din", copro_din, 128'h1f1e1d1c1b1a19181716151413121110);
        send_crst();
        wait_done("crst");

        // Reset after 7 payload bytes discards the frame
        send_byte(8'h01);
        for (int i = 0; i < 7; i++) send_byte(8'hC0 + 8'(i));
        do_reset();
        idle(30);
        check("midrst_busy", WD'(busy), '0);
        check("midrst_din", copro_din, '0);
        check("midrst_tx_valid", WD'(tx_valid), '0);

        // Extra byte during settle sets sticky overrun
        send_load(128'hA5);
        idle(3);
        send_byte(8'h55);
        ovr_exp = 1'b1;
        wait_done("ovr_load");
        check("ovr_set", WD'(overrun), WD'(1'b1));
        send_crst();
        wait_done("ovr_crst");
        check("ovr_sticky", WD'(overrun), WD'(1'b1));
        do_reset();
        check("ovr_cleared", WD'(overrun), '0);

`ifdef SEQ_TIMEOUT_EN
        // Partial LOAD times out into an error reply with no strobe
        push(8'hEE, 0);
        send_byte(8'h01);
        for (int i = 0; i < 3; i++) send_byte(8'h90 + 8'(i));
        wait_done("timeout");
`endif

        idle(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
